// File: rtl/interrupt_scheduler.sv
// Round-robin interrupt scheduler with edge-latched, coalescing pending bits.
// Optional per-source arbitration mask enabled by defining IRQ_MASK_EN.
module interrupt_scheduler #(
    parameter int         NUM_SRC     = 4,
    parameter logic [4:0] INT_OPCODE  = 5'b10110,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic               frame_rt_clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic               cpu_ack,
`ifdef IRQ_MASK_EN
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
`endif
    output logic               irq_valid,
    output logic [31:0]        irq_instruction,
    output logic [4:0]         irq_src,
    output logic [NUM_SRC-1:0] pending,
    output logic [7:0]         coalesce_cnt,
    output logic [7:0]         timeout_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] req_q, pend_q, pend_d;
    logic [NUM_SRC-1:0] new_req, elig, sel_oh, src_oh, hits;
    logic [4:0]         rr_q, rr_d, src_q, src_d, sel;
    logic               valid_q, valid_d, found, issue, tmo;
    logic [15:0]        tmr_q, tmr_d;
    logic [7:0]         coal_q, coal_d, tout_q, tout_d;
    logic [5:0]         nhits;
    logic [8:0]         csum;

    assign new_req = irq_req & ~req_q;

`ifdef IRQ_MASK_EN
    logic [NUM_SRC-1:0] mask_q;

    always_ff @(posedge frame_rt_clk or posedge reset) begin
        if (reset) begin
            mask_q <= '1;
        end else if (mask_wr) begin
            mask_q <= mask_data;
        end
    end

    assign elig = pend_q & mask_q;
`else
    assign elig = pend_q;
`endif

    // Priority distance from rr_q+1; the nearest eligible source wins.
    always_comb begin : arb
        int best;
        int d;
        best  = NUM_SRC;
        found = 1'b0;
        sel   = rr_q;
        for (int c = 0; c < NUM_SRC; c++) begin
            d = c - int'(rr_q) - 1;
            if (d < 0) d = d + NUM_SRC;
            if (elig[c] && d < best) begin
                best  = d;
                sel   = 5'(c);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_oh[i] = (sel == 5'(i));
            src_oh[i] = (src_q == 5'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        src_d   = src_q;
        rr_d    = rr_q;
        tmr_d   = tmr_q;
        issue   = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    issue   = 1'b1;
                    valid_d = 1'b1;
                    src_d   = sel;
                    rr_d    = sel;
                    tmr_d   = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (cpu_ack) begin
                    valid_d = 1'b0;
                    state_d = GAP;
                end else if (ACK_TIMEOUT != 0 &&
                             tmr_q == 16'(ACK_TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    valid_d = 1'b0;
                    state_d = GAP;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A fresh edge on the source being issued re-arms it rather than coalescing.
    always_comb begin
        pend_d = pend_q;
        if (issue) pend_d = pend_d & ~sel_oh;
        if (tmo)   pend_d = pend_d | src_oh;
        pend_d = pend_d | new_req;

        hits = new_req & pend_q & ~(issue ? sel_oh : '0);
        nhits = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            nhits = nhits + 6'(hits[i]);
        end
        csum   = {1'b0, coal_q} + {3'b0, nhits};
        coal_d = csum[8] ? 8'hFF : csum[7:0];
        tout_d = (tmo && tout_q != 8'hFF) ? tout_q + 8'd1 : tout_q;
    end

    always_ff @(posedge frame_rt_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            pend_q  <= '0;
            rr_q    <= 5'(NUM_SRC - 1);
            src_q   <= '0;
            valid_q <= 1'b0;
            tmr_q   <= '0;
            coal_q  <= '0;
            tout_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= irq_req;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            tmr_q   <= tmr_d;
            coal_q  <= coal_d;
            tout_q  <= tout_d;
        end
    end

    assign irq_valid       = valid_q;
    assign irq_src         = src_q;
    assign irq_instruction = valid_q ? {INT_OPCODE, 22'b0, src_q} : 32'h0;
    assign pending         = pend_q;
    assign coalesce_cnt    = coal_q;
    assign timeout_cnt     = tout_q;

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Bench for interrupt_scheduler: spec-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_interrupt_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk;
    logic         reset;
    logic [N-1:0] irq_req;
    logic         cpu_ack;
    logic         irq_valid;
    logic [31:0]  irq_instruction;
    logic [4:0]   irq_src;
    logic [N-1:0] pending;
    logic [7:0]   coalesce_cnt;
    logic [7:0]   timeout_cnt;
`ifdef IRQ_MASK_EN
    logic         mask_wr;
    logic [N-1:0] mask_data;
`endif

    int checks = 0;
    int errors = 0;

    interrupt_scheduler #(
        .NUM_SRC(N), .INT_OPCODE(5'b10110), .ACK_TIMEOUT(TO)
    ) dut (
        .frame_rt_clk   (clk),
        .reset          (reset),
        .irq_req        (irq_req),
        .cpu_ack        (cpu_ack),
`ifdef IRQ_MASK_EN
        .mask_wr        (mask_wr),
        .mask_data      (mask_data),
`endif
        .irq_valid      (irq_valid),
        .irq_instruction(irq_instruction),
        .irq_src        (irq_src),
        .pending        (pending),
        .coalesce_cnt   (coalesce_cnt),
        .timeout_cnt    (timeout_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending set, busy phase, last-served pointer, counters.
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_prev = '0;
    logic [N-1:0] m_mask = '1;
    int           m_phase = 0;
    int           m_ptr = N - 1;
    logic [4:0]   m_src = '0;
    bit           m_valid = 1'b0;
    int           m_age = 0;
    int           m_coal = 0;
    int           m_tout = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend = '0; m_prev = '0; m_mask = '1; m_phase = 0;
            m_ptr = N - 1; m_src = '0; m_valid = 0; m_age = 0;
            m_coal = 0; m_tout = 0;
        end else begin
            logic [N-1:0] rise, nxt;
            int sel;
            rise = irq_req & ~m_prev;
            nxt  = m_pend;
            sel  = -1;
            if (m_phase == 0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (sel < 0 && m_pend[c] && m_mask[c]) sel = c;
                end
                if (sel >= 0) begin
                    nxt[sel] = 1'b0;
                    m_src = 5'(sel); m_ptr = sel;
                    m_valid = 1; m_age = 1; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (cpu_ack) begin
                    m_valid = 0; m_phase = 2;
                end else if (TO != 0 && m_age == TO) begin
                    nxt[m_src] = 1'b1;
                    if (m_tout < 255) m_tout++;
                    m_valid = 0; m_phase = 2;
                end else begin
                    m_age++;
                end
            end else begin
                m_phase = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (rise[i]) begin
                    if (m_pend[i] && i != sel && m_coal < 255) m_coal++;
                    nxt[i] = 1'b1;
                end
            end
            m_pend = nxt;
            m_prev = irq_req;
`ifdef IRQ_MASK_EN
            if (mask_wr) m_mask = mask_data;
`endif
        end
        #1;
        chk("m_valid", 32'(irq_valid), 32'(m_valid));
        chk("m_instr", irq_instruction,
            m_valid ? {5'b10110, 22'b0, m_src} : 32'h0);
        chk("m_src", 32'(irq_src), 32'(m_src));
        chk("m_pending", 32'(pending), 32'(m_pend));
        chk("m_coal", 32'(coalesce_cnt), 32'(m_coal));
        chk("m_tout", 32'(timeout_cnt), 32'(m_tout));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int i;
        i = 0;
        while (!irq_valid && i < 40) begin
            step(1);
            i++;
        end
        chk(name, 32'(irq_valid), 32'd1);
    endtask

    int got [3];
    int cnt;

    initial begin
        reset = 1'b1; irq_req = '0; cpu_ack = 1'b0;
`ifdef IRQ_MASK_EN
        mask_wr = 1'b0; mask_data = '1;
`endif
        step(2);
        reset = 1'b0;
        chk("rst_valid", 32'(irq_valid), 32'd0);
        chk("rst_instr", irq_instruction, 32'h0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_coal", 32'(coalesce_cnt), 32'd0);

        // Single request: latency and instruction encoding
        irq_req = 4'b0010;
        step(1);
        chk("t1_pending", 32'(pending), 32'h2);
        chk("t1_valid_lo", 32'(irq_valid), 32'd0);
        step(1);
        chk("t1_valid", 32'(irq_valid), 32'd1);
        chk("t1_src", 32'(irq_src), 32'd1);
        chk("t1_instr", irq_instruction, 32'hB000_0001);
        chk("t1_pend_clr", 32'(pending), 32'h0);
        cpu_ack = 1'b1;
        step(1);
        cpu_ack = 1'b0;
        chk("t1_drop", 32'(irq_valid), 32'd0);
        chk("t1_instr0", irq_instruction, 32'h0);
        step(2);

        // Round-robin order 0,1,3
        irq_req = '0;
        do_reset();
        irq_req = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            wait_valid("t2_wait");
            got[k] = int'(irq_src);
            cpu_ack = 1'b1;
            step(1);
            cpu_ack = 1'b0;
            chk("t2_gap", 32'(irq_valid), 32'd0);
        end
        chk("t2_ord0", 32'(got[0]), 32'd0);
        chk("t2_ord1", 32'(got[1]), 32'd1);
        chk("t2_ord2", 32'(got[2]), 32'd3);

        // Coalescing while src0 holds the handshake
        irq_req = '0;
        do_reset();
        irq_req = 4'b0001;
        step(2);
        chk("t3_src0", 32'(irq_src), 32'd0);
        irq_req = 4'b0101; step(1);
        irq_req = 4'b0001; step(1);
        irq_req = 4'b0101; step(1);
        irq_req = 4'b0001; step(1);
        irq_req = 4'b0101; step(1);
        chk("t3_coal", 32'(coalesce_cnt), 32'd2);
        chk("t3_pend", 32'(pending), 32'h4);
        cpu_ack = 1'b1; step(1); cpu_ack = 1'b0;
        wait_valid("t3_wait");
        chk("t3_src2", 32'(irq_src), 32'd2);
        cpu_ack = 1'b1; step(1); cpu_ack = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (irq_valid) cnt++;
        end
        chk("t3_single", 32'(cnt), 32'd0);
        chk("t3_pend0", 32'(pending), 32'h0);

        // Ack timeout and re-issue
        irq_req = '0;
        do_reset();
        irq_req = 4'b1000;
        wait_valid("t4_wait");
        cnt = 0;
        while (irq_valid && cnt < 40) begin
            cnt++;
            step(1);
        end
        chk("t4_hold", 32'(cnt), 32'd16);
        chk("t4_tout", 32'(timeout_cnt), 32'd1);
        chk("t4_requeue", 32'(pending), 32'h8);
        step(1);
        chk("t4_gap", 32'(irq_valid), 32'd0);
        step(1);
        chk("t4_reissue", 32'(irq_valid), 32'd1);
        chk("t4_src", 32'(irq_src), 32'd3);

        // Asynchronous reset mid-handshake
        reset = 1'b1;
        irq_req = '0;
        #1;
        chk("t5_valid", 32'(irq_valid), 32'd0);
        chk("t5_instr", irq_instruction, 32'h0);
        chk("t5_pend", 32'(pending), 32'h0);
        chk("t5_tout", 32'(timeout_cnt), 32'd0);
        chk("t5_src", 32'(irq_src), 32'd0);
        step(1);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (irq_valid) cnt++;
        end
        chk("t5_noissue", 32'(cnt), 32'd0);

`ifdef IRQ_MASK_EN
        // Masked source stays pending until unmasked
        mask_data = 4'b1110; mask_wr = 1'b1;
        step(1);
        mask_wr = 1'b0;
        irq_req = 4'b0011;
        wait_valid("t6_wait");
        chk("t6_src1", 32'(irq_src), 32'd1);
        cpu_ack = 1'b1; step(1); cpu_ack = 1'b0;
        step(4);
        chk("t6_masked", 32'(irq_valid), 32'd0);
        chk("t6_pend", 32'(pending), 32'h1);
        mask_data = 4'b1111; mask_wr = 1'b1;
        step(1);
        mask_wr = 1'b0;
        wait_valid("t6_wait0");
        chk("t6_src0", 32'(irq_src), 32'd0);
        cpu_ack = 1'b1; step(1); cpu_ack = 1'b0;
        step(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
